// File: rtl/button_scan_ctrl.sv
// Debounce controller for a bank of active-low buttons sharing one qualification
// counter, granted round-robin; committed changes are posted to a one-entry event register.
module button_scan_ctrl #(
    parameter int N_BTN = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb_n,
    output logic [N_BTN-1:0] pb_state,
    output logic [N_BTN-1:0] pb_down,
    output logic [N_BTN-1:0] pb_up,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_press,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

    state_t             state_reg, state_next;
    logic [N_BTN-1:0]   sync0_reg, sync1_reg;
    logic [N_BTN-1:0]   pending;
    logic [ID_W-1:0]    sel_reg, sel_next;
    logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N_BTN-1:0]   pb_state_next, pb_down_next, pb_up_next;
    logic               evt_valid_next, evt_press_next;
    logic [ID_W-1:0]    evt_id_next;
    logic               hit;
    logic [ID_W-1:0]    hit_idx, cand;
    logic               new_level;
    int                 scan_sum;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_pending
            assign pending[gi] = sync1_reg[gi] ^ pb_state[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        rr_ptr_next    = rr_ptr_reg;
        cnt_next       = cnt_reg;
        pb_state_next  = pb_state;
        pb_down_next   = '0;
        pb_up_next     = '0;
        evt_valid_next = evt_valid;
        evt_id_next    = evt_id;
        evt_press_next = evt_press;
        hit            = 1'b0;
        hit_idx        = '0;
        cand           = '0;
        new_level      = 1'b0;
        scan_sum       = 0;

        // Scan from the highest offset down so the lowest offset from rr_ptr wins.
        for (int k = N_BTN - 1; k >= 0; k--) begin
            scan_sum = int'(rr_ptr_reg) + k;
            if (scan_sum >= N_BTN)
                scan_sum = scan_sum - N_BTN;
            cand = ID_W'(scan_sum);
            if (pending[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end

        if (evt_valid && evt_ready)
            evt_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (hit) begin
                    sel_next    = hit_idx;
                    rr_ptr_next = (int'(hit_idx) == N_BTN - 1) ? '0 : hit_idx + ID_W'(1);
                    cnt_next    = '0;
                    state_next  = COUNT;
                end
            end
            COUNT: begin
                if (!pending[sel_reg]) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (&cnt_reg) begin
                    state_next = COMMIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            COMMIT: begin
                // The change is final here; pending is deliberately not rechecked.
                if (!evt_valid || evt_ready) begin
                    new_level               = ~pb_state[sel_reg];
                    pb_state_next[sel_reg]  = new_level;
                    if (new_level)
                        pb_down_next[sel_reg] = 1'b1;
                    else
                        pb_up_next[sel_reg]   = 1'b1;
                    evt_id_next    = sel_reg;
                    evt_press_next = new_level;
                    evt_valid_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_reg  <= '0;
            sync1_reg  <= '0;
            state_reg  <= IDLE;
            sel_reg    <= '0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
            pb_state   <= '0;
            pb_down    <= '0;
            pb_up      <= '0;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_press  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync0_reg  <= ~pb_n;
            sync1_reg  <= sync0_reg;
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            pb_state   <= pb_state_next;
            pb_down    <= pb_down_next;
            pb_up      <= pb_up_next;
            evt_valid  <= evt_valid_next;
            evt_id     <= evt_id_next;
            evt_press  <= evt_press_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with a 16-cycle qualification window:
// per-edge sweep of a single press, a phase table, and a mid-count reset.
module tb_button_scan_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  pb_n;
    logic [N-1:0]  pb_state, pb_down, pb_up;
    logic          evt_valid, evt_ready, evt_press, busy;
    logic [IW-1:0] evt_id;

    button_scan_ctrl #(.N_BTN(N), .ID_W(IW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_n      (pb_n),
        .pb_state  (pb_state),
        .pb_down   (pb_down),
        .pb_up     (pb_up),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] pb_n;
        logic       ready;
        int         edges;
        logic [3:0] st;
        logic [3:0] dn;
        logic [3:0] up;
        logic       valid;
        logic [1:0] id;
        logic       press;
        logic       bsy;
    } vec_t;

    vec_t tbl[34];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] dn,
                           input logic [3:0] up, input logic vl, input logic [1:0] id,
                           input logic pr, input logic bs);
        chk({tag, ".pb_state"},  32'(pb_state),  32'(st));
        chk({tag, ".pb_down"},   32'(pb_down),   32'(dn));
        chk({tag, ".pb_up"},     32'(pb_up),     32'(up));
        chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(vl));
        chk({tag, ".evt_id"},    32'(evt_id),    32'(id));
        chk({tag, ".evt_press"}, 32'(evt_press), 32'(pr));
        chk({tag, ".busy"},      32'(busy),      32'(bs));
    endtask

    initial begin
        // release btn1
        tbl[0]  = '{4'b1101, 1'b1,  1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 19, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1};
        tbl[2]  = '{4'b1111, 1'b0,  1, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
        // bounce on btn0, then a stable press and release
        tbl[4]  = '{4'b1110, 1'b0, 10, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[5]  = '{4'b1111, 1'b0,  5, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{4'b1110, 1'b0, 19, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[7]  = '{4'b1110, 1'b0,  1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{4'b1110, 1'b1,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 19, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1};
        tbl[10] = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        // btn2 and btn3 together, rr_ptr=1: 2 at edge 20, 3 at edge 38
        tbl[12] = '{4'b0011, 1'b1, 19, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[13] = '{4'b0011, 1'b1,  1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[14] = '{4'b0011, 1'b1,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1};
        tbl[15] = '{4'b0011, 1'b1, 16, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1};
        tbl[16] = '{4'b0011, 1'b1,  1, 4'b1100, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[17] = '{4'b0011, 1'b1,  1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[18] = '{4'b1111, 1'b1, 20, 4'b1000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[19] = '{4'b1111, 1'b1, 18, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[20] = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        // btn2 press and release leave rr_ptr=3; then 2 and 3 together serve 3 first
        tbl[21] = '{4'b1011, 1'b1, 20, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[22] = '{4'b1011, 1'b1,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[23] = '{4'b1111, 1'b1, 20, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[24] = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[25] = '{4'b0011, 1'b1, 20, 4'b1000, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[26] = '{4'b0011, 1'b1, 18, 4'b1100, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[27] = '{4'b0011, 1'b1,  1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0};
        // backpressure: btn3 event left unconsumed while btn2 release qualifies
        tbl[28] = '{4'b1011, 1'b0, 20, 4'b0100, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[29] = '{4'b1111, 1'b0, 20, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b1};
        tbl[30] = '{4'b1111, 1'b0,  5, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b1};
        tbl[31] = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[32] = '{4'b1111, 1'b0,  3, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[33] = '{4'b1111, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};

        rst_n     = 1'b0;
        pb_n      = 4'b1111;
        evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        $display("reset: pb_state=%b evt_valid=%b busy=%b", pb_state, evt_valid, busy);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single press of btn1, tracked edge by edge.
        pb_n = 4'b1101;
        for (int e = 1; e <= 22; e++) begin
            wait_edges(1);
            chk($sformatf("press1.e%0d.pb_down", e),  32'(pb_down),  (e == 20) ? 32'h2 : 32'h0);
            chk($sformatf("press1.e%0d.pb_state", e), 32'(pb_state), (e >= 20) ? 32'h2 : 32'h0);
            if (e == 20) begin
                chk("press1.evt_valid", 32'(evt_valid), 32'h1);
                chk("press1.evt_id",    32'(evt_id),    32'h1);
                chk("press1.evt_press", 32'(evt_press), 32'h1);
            end
            $display("press1 edge %0d: pb_state=%b pb_down=%b evt_valid=%b", e, pb_state, pb_down, evt_valid);
        end

        for (int i = 0; i < 34; i++) begin
            pb_n      = tbl[i].pb_n;
            evt_ready = tbl[i].ready;
            wait_edges(tbl[i].edges);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].dn, tbl[i].up,
                    tbl[i].valid, tbl[i].id, tbl[i].press, tbl[i].bsy);
            $display("vec %0d: pb_n=%b ready=%b edges=%0d -> pb_state=%b dn=%b up=%b valid=%b id=%0d press=%b busy=%b",
                     i, pb_n, evt_ready, tbl[i].edges, pb_state, pb_down, pb_up, evt_valid, evt_id, evt_press, busy);
        end

        // Reset while btn1 is counting (cnt = 7), then full re-qualification.
        pb_n      = 4'b1101;
        evt_ready = 1'b1;
        wait_edges(10);
        chk("midcount.busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        $display("reset mid-count: pb_state=%b evt_valid=%b evt_id=%0d busy=%b", pb_state, evt_valid, evt_id, busy);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(19);
        chk("requal.e19.pb_state", 32'(pb_state), 32'h0);
        chk("requal.e19.busy",     32'(busy),     32'h1);
        wait_edges(1);
        chk_all("requal.e20", 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0);
        $display("requal edge 20: pb_state=%b pb_down=%b evt_valid=%b id=%0d", pb_state, pb_down, evt_valid, evt_id);
        wait_edges(1);
        chk("requal.e21.pb_down",   32'(pb_down),   32'h0);
        chk("requal.e21.evt_valid", 32'(evt_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_scan_ctrl.md
# button_scan_ctrl

Debounce controller for a bank of N_BTN active-low push-buttons that share one debounce counter. A round-robin scheduler grants the counter to whichever button shows a pending level change. The block qualifies that change over 2^CNT_W cycles, then commits it. Outputs are per-button stable state, one-cycle press/release pulses, and a single-entry event register with a valid/ready handshake for the VGA front-end logic.

## Interface
- N_BTN, 4, number of buttons (≥2)
- ID_W, 2, width of button index; must satisfy 2^ID_W ≥ N_BTN
- CNT_W, 16, shared counter width; qualification window = 2^CNT_W cycles
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pb_n  in  N_BTN  raw glitchy buttons, asynchronous, active low (0 = pressed)
- pb_state  out  N_BTN  debounced state, 1 = held down
- pb_down  out  N_BTN  one-cycle pulse on committed press
- pb_up  out  N_BTN  one-cycle pulse on committed release
- evt_valid  out  1  event register holds an unconsumed event
- evt_ready  in  1  consumer accepts the event when high with evt_valid
- evt_id  out  ID_W  index of the button in the event
- evt_press  out  1  1 = press, 0 = release
- busy  out  1  FSM not in IDLE

## Operation
- Reset (async assert): sync0/sync1 = 0, pb_state = 0, pb_down = pb_up = 0, evt_valid = 0, evt_id = 0, evt_press = 0, cnt = 0, sel = 0, rr_ptr = 0, state = IDLE, busy = 0.
- Synchronizer per button: sync0 <= ~pb_n; sync1 <= sync0. Only sync1 is used downstream.
- pending[i] = sync1[i] ^ pb_state[i].
- FSM states are IDLE, COUNT and COMMIT.
- IDLE: search indices rr_ptr, rr_ptr+1, … wrapping modulo N_BTN, all in one cycle. The first pending index wins.
  - On a hit: sel <= idx; rr_ptr <= (idx+1) mod N_BTN; cnt <= 0; go to COUNT.
  - No hit: stay in IDLE; rr_ptr unchanged.
- COUNT, checked in this order:
  - If !pending[sel]: abort (bounce). cnt <= 0; go to IDLE.
  - Else if cnt is all ones: go to COMMIT.
  - Else: cnt <= cnt + 1. Unsigned CNT_W-bit; never wraps, because the all-ones case exits first.
- COMMIT: the slot is free when !evt_valid or evt_ready.
  - When the slot is free: toggle pb_state[sel]. Pulse pb_down[sel] if the new state is 1, else pb_up[sel]. Load evt_id <= sel, evt_press <= new state, evt_valid <= 1. Go to IDLE.
  - When the slot is not free: hold in COMMIT with no output change. pending is not rechecked; the commit is final.
- Event register:
  - evt_valid && evt_ready with no load in the same cycle: evt_valid <= 0.
  - Accept and load in the same cycle: the new event replaces the old one and evt_valid stays 1.
  - evt_id and evt_press hold stable while evt_valid = 1 and no accept occurs.
- Only one button is ever qualified at a time. Other buttons' changes wait as pending and are picked up in round-robin order.
- A button that releases during its own COMMIT wait is committed as pressed. The release becomes pending and is handled on a later scan.

## Timing
- Latency: the edge that first samples a new pb_n level is edge 1. pb_state, the pb_down/pb_up pulse and evt_valid all update on edge 2^CNT_W + 4.
  - This assumes a stable input, an idle FSM and a free event slot.
  - Each cycle of evt_ready backpressure adds one cycle.
- pb_down and pb_up are registered and high for exactly one clk cycle. They are mutually exclusive, and at most one bit across the bank is high per cycle.
- Qualification requires pending[sel] = 1 on all 2^CNT_W COUNT cycles. A single low cycle aborts and costs 1 extra IDLE cycle before the next grant.
- rst_n asserted mid-COUNT or mid-COMMIT forces the reset values immediately; no event is emitted. After release, buttons still held are re-qualified from scratch.
- Every output is driven from a register; no combinational path from pb_n or evt_ready to any output.

## Test plan
- Single press, CNT_W = 4: pb_n[1] goes 1→0 and holds. Required: pb_state[1] = 1 and a one-cycle pb_down[1] on edge 20; evt_valid = 1, evt_id = 1, evt_press = 1. Release gives pb_up[1] after the same latency.
- Bounce, CNT_W = 4: pb_n[0] low for 10 cycles, then high. Required: no pulse, pb_state[0] stays 0, FSM returns to IDLE. A stable low afterwards is committed normally.
- Simultaneous, CNT_W = 4, rr_ptr = 0: pb_n[2] and pb_n[3] fall on the same edge. Required: button 2 commits first, then button 3 commits 2^CNT_W + 2 cycles later; events arrive in order 2, 3. Repeat with rr_ptr = 3 (after a button-2 event): button 3 is served first.
- Backpressure: evt_ready = 0 with one unconsumed event while a second button qualifies. Required: FSM holds in COMMIT and pb_state is unchanged. The commit happens on the edge after evt_ready = 1 is seen.
- Reset mid-COUNT: assert rst_n = 0 at cnt = 7 with the button still held. Required: all outputs at reset values immediately. After release, full re-qualification, with the event on edge 2^CNT_W + 4 relative to the first post-reset sample.
